// File: rtl/mmio_uart_tx_if.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx_if
//   Processor data-bus bundle that connects a load/store initiator to a
//   memory-mapped responder.
//
//   Signals
//     mem_valid  initiator -> responder  request; held until mem_ready
//     mem_addr   initiator -> responder  32-bit byte address
//     mem_wdata  initiator -> responder  32-bit store data
//     mem_wstrb  initiator -> responder  byte strobes, 4'b0000 means load
//     mem_ready  responder -> initiator  one-cycle acknowledge pulse
//     mem_rdata  responder -> initiator  load data, valid while mem_ready=1
//
//   Modports
//     master  the load/store initiator (processor side)
//     slave   the memory-mapped responder (peripheral side)
// ---------------------------------------------------------------------------
interface mmio_uart_tx_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped UART transmitter sitting on the processor data bus.
//   Stores to TXDATA push bytes into a TX FIFO; an 8N1 serializer drains the
//   FIFO onto uart_tx. Firmware polls STATUS for flow control.
//
//   Register window (16 bytes at BASE_ADDR, offset = mem_addr[3:2])
//     0x0 TXDATA  store with wstrb[0]=1 pushes wdata[7:0]; load returns 0
//     0x4 STATUS  {16'b0, count[7:0], 4'b0, parityEn, empty, full, busy}
//     0x8/0xC     loads return 0, stores ignored (both acknowledged)
//
//   Ports
//     clock    in   system clock, all state on the rising edge
//     reset    in   asynchronous active-high reset, clears all state
//     bus      slave modport of mmio_uart_tx_if (mem_valid/addr/wdata/wstrb
//              in, mem_ready/rdata out)
//     uart_tx  out  serial line, idle high, driven from a register
//
//   Build option
//     UART_TX_PARITY_EN  when defined, an even-parity bit is sent after the
//                        eight data bits and STATUS bit 3 reads 1.
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter int          CLK_HZ     = 12_500_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic           clock,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           uart_tx
);

  localparam int             DIV      = CLK_HZ / BAUD;
  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);
  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam int             NW       = AW + 1;
  localparam logic [NW-1:0]  DEPTH_N  = NW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   baudCnt_q;
  logic [2:0]      bitIdx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  logic [7:0]      fifoMem [FIFO_DEPTH];
  logic [AW-1:0]   wrPtr_q;
  logic [AW-1:0]   rdPtr_q;
  logic [NW-1:0]   count_q;

  logic            ready_q;
  logic [31:0]     rdata_q;
  logic            acked_q;

  logic            selected;
  logic [1:0]      offset;
  logic            txPush;
  logic            accept;
  logic            pushFire;
  logic            popFire;
  logic            baudLast;
  logic            fifoEmpty;
  logic            fifoFull;
  logic            busy;
  logic [8:0]      countWide;
  logic [31:0]     statusWord;
  logic [31:0]     readData;
  logic [7:0]      fifoHead;
  logic            unusedBus;

  assign selected  = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = bus.mem_addr[3:2];
  assign txPush    = (offset == 2'd0) && bus.mem_wstrb[0];
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == DEPTH_N);

  // A request is taken once per mem_valid assertion; a TXDATA push into a
  // full FIFO stalls here until the serializer frees a slot.
  assign accept    = selected && !acked_q && !(txPush && fifoFull);
  assign pushFire  = accept && txPush;

  // The serializer pulls the next byte either from IDLE or at the very end
  // of a stop bit, so back-to-back bytes go out without an idle gap.
  assign baudLast  = (baudCnt_q == DIV_LAST);
  assign popFire   = !fifoEmpty && ((state_q == IDLE) || ((state_q == STOP) && baudLast));

  assign busy       = (state_q != IDLE) || !fifoEmpty;
  assign countWide  = 9'(count_q);
  assign statusWord = {16'b0, countWide[7:0], 4'b0, PARITY_FLAG, fifoEmpty, fifoFull, busy};
  assign fifoHead   = fifoMem[rdPtr_q];

  assign unusedBus  = ^{bus.mem_addr[1:0], bus.mem_wdata[31:8], bus.mem_wstrb[3:1]};

  // Read mux: only STATUS returns anything, every other offset reads zero.
  always_comb begin
    readData = 32'b0;
    if (offset == 2'd1) begin
      readData = statusWord;
    end
  end

  // Bus responder: one-cycle ready pulse with registered read data. The
  // acked flag stays set until mem_valid drops so a held request is only
  // acknowledged once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= 32'b0;
      acked_q <= 1'b0;
    end else begin
      if (accept) begin
        ready_q <= 1'b1;
        rdata_q <= readData;
        acked_q <= 1'b1;
      end else begin
        ready_q <= 1'b0;
        rdata_q <= 32'b0;
        if (!bus.mem_valid) begin
          acked_q <= 1'b0;
        end
      end
    end
  end

  // FIFO storage has no reset; the pointers and count define what is valid,
  // so clearing them discards any queued bytes.
  always_ff @(posedge clock) begin
    if (pushFire) begin
      fifoMem[wrPtr_q] <= bus.mem_wdata[7:0];
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth; a simultaneous
  // push and pop leaves the count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushFire) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (popFire) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({pushFire, popFire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serializer FSM. Every state lasts DIV cycles, the baud counter restarts
  // on each state entry, and the line level for the next state is loaded
  // into tx_q on the transition so uart_tx never glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q      <= 1'b1;
          baudCnt_q <= '0;
          if (popFire) begin
            shift_q  <= fifoHead;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^fifoHead;
`endif
            state_q  <= START;
            tx_q     <= 1'b0;
          end
        end

        START: begin
          if (baudLast) begin
            state_q   <= DATA;
            baudCnt_q <= '0;
            bitIdx_q  <= 3'd0;
            tx_q      <= shift_q[0];
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end

        DATA: begin
          if (baudLast) begin
            baudCnt_q <= '0;
            if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              shift_q  <= shift_q >> 1;
              tx_q     <= shift_q[1];
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baudLast) begin
            state_q   <= STOP;
            baudCnt_q <= '0;
            tx_q      <= 1'b1;
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end
`endif

        STOP: begin
          if (baudLast) begin
            baudCnt_q <= '0;
            if (popFire) begin
              shift_q  <= fifoHead;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^fifoHead;
`endif
              state_q  <= START;
              tx_q     <= 1'b0;
            end else begin
              state_q  <= IDLE;
              tx_q     <= 1'b1;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end

        default: begin
          state_q   <= IDLE;
          baudCnt_q <= '0;
          tx_q      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign uart_tx       = tx_q;

endmodule
